// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port (I) and a data port (D) onto one memory
// command port. Requests are captured into per-port holding registers, granted
// round-robin, and the memory response (or a timeout) is routed back to the
// port that owns the bus.

module mem_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  nrst,
    // fetch port
    input  logic [ADDR_WIDTH-1:0] i_IAddr,
    input  logic                  i_IRdC,
    output logic [DATA_WIDTH-1:0] o_IData,
    output logic                  o_IRdy,
    output logic                  o_IErr,
    // data port
    input  logic [ADDR_WIDTH-1:0] i_DAddr,
    input  logic                  i_DCmd,
    input  logic                  i_DRnW,
    input  logic [BEN_WIDTH-1:0]  i_DBen,
    input  logic [DATA_WIDTH-1:0] i_DData,
    output logic [DATA_WIDTH-1:0] o_DData,
    output logic                  o_DRdy,
    output logic                  o_DErr,
    // memory port
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic                  o_MCmd,
    output logic                  o_MRnW,
    output logic [BEN_WIDTH-1:0]  o_MBen,
    output logic [DATA_WIDTH-1:0] o_MData,
    input  logic [DATA_WIDTH-1:0] i_MData,
    input  logic                  i_MRdy,
    input  logic                  i_MErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    // Counter is wide enough to reach TIMEOUT; a 1-bit dummy when disabled.
    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic             TMO_EN    = (TIMEOUT > 0);

    // FSM and arbitration state
    state_t                state_q, state_d;
    logic                  last_d_q, last_d_d;   // 1: data port was served last
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Holding registers; the pending flag stays set while the request is in flight
    logic                  i_pend_q, i_pend_d;
    logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
    logic                  d_pend_q, d_pend_d;
    logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
    logic                  d_rnw_q, d_rnw_d;
    logic [BEN_WIDTH-1:0]  d_ben_q, d_ben_d;
    logic [DATA_WIDTH-1:0] d_data_q, d_data_d;

    // Registered memory-side outputs
    logic                  m_cmd_q, m_cmd_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic                  m_rnw_q, m_rnw_d;
    logic [BEN_WIDTH-1:0]  m_ben_q, m_ben_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    // Combinational helpers
    logic                  i_stb_s, d_stb_s;
    logic                  i_req_s, d_req_s;
    logic [ADDR_WIDTH-1:0] i_addr_s, d_addr_s;
    logic                  d_rnw_s;
    logic [BEN_WIDTH-1:0]  d_ben_s;
    logic [DATA_WIDTH-1:0] d_data_s;
    logic                  busy_s, tmo_s, err_s, rdy_s, done_s;
    logic                  gnt_i_s, gnt_d_s;

    // Effective requests: a held request, or a strobe accepted this very cycle.
    always_comb begin
        i_stb_s = i_IRdC & ~i_pend_q;
        d_stb_s = i_DCmd & ~d_pend_q;
        i_req_s = i_pend_q | i_stb_s;
        d_req_s = d_pend_q | d_stb_s;
        if (i_pend_q) begin
            i_addr_s = i_addr_q;
        end else begin
            i_addr_s = i_IAddr;
        end
        if (d_pend_q) begin
            d_addr_s = d_addr_q;
            d_rnw_s  = d_rnw_q;
            d_ben_s  = d_ben_q;
            d_data_s = d_data_q;
        end else begin
            d_addr_s = i_DAddr;
            d_rnw_s  = i_DRnW;
            d_ben_s  = i_DBen;
            d_data_s = i_DData;
        end
    end

    // Qualify the memory response; error (including timeout) beats ready.
    always_comb begin
        busy_s = (state_q == IBUS) || (state_q == DBUS);
        tmo_s  = TMO_EN & busy_s & (cnt_q == TMO_LIMIT);
        err_s  = busy_s & (i_MErr | tmo_s);
        rdy_s  = busy_s & i_MRdy & ~err_s;
        done_s = err_s | rdy_s;
    end

    // Pick the port that owns the bus after the next edge.
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    gnt_i_s = last_d_q;
                    gnt_d_s = ~last_d_q;
                end else begin
                    gnt_i_s = i_req_s;
                    gnt_d_s = d_req_s;
                end
            end
            // A finishing transaction hands straight over to the other port
            IBUS: begin
                gnt_d_s = done_s & d_req_s;
            end
            DBUS: begin
                gnt_i_s = done_s & i_req_s;
            end
            default: begin
                gnt_i_s = 1'b0;
                gnt_d_s = 1'b0;
            end
        endcase
    end

    // Next-state: strobe capture, completion bookkeeping, timeout count, grant.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        i_addr_d = i_addr_q;
        d_addr_d = d_addr_q;
        d_rnw_d  = d_rnw_q;
        d_ben_d  = d_ben_q;
        d_data_d = d_data_q;
        m_cmd_d  = 1'b0;
        m_addr_d = m_addr_q;
        m_rnw_d  = m_rnw_q;
        m_ben_d  = m_ben_q;
        m_data_d = m_data_q;

        if (i_stb_s) begin
            i_pend_d = 1'b1;
            i_addr_d = i_IAddr;
        end else begin
            i_pend_d = i_pend_q;
        end

        if (d_stb_s) begin
            d_pend_d = 1'b1;
            d_addr_d = i_DAddr;
            d_rnw_d  = i_DRnW;
            d_ben_d  = i_DBen;
            d_data_d = i_DData;
        end else begin
            d_pend_d = d_pend_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
            end
            IBUS: begin
                if (done_s) begin
                    i_pend_d = 1'b0;
                    last_d_d = 1'b0;
                    state_d  = IDLE;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DBUS: begin
                if (done_s) begin
                    d_pend_d = 1'b0;
                    last_d_d = 1'b1;
                    state_d  = IDLE;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (gnt_i_s) begin
            state_d  = IBUS;
            cnt_d    = CNT_ZERO;
            m_cmd_d  = 1'b1;
            m_addr_d = i_addr_s;
            m_rnw_d  = 1'b1;
            m_ben_d  = {BEN_WIDTH{1'b1}};
            m_data_d = {DATA_WIDTH{1'b0}};
        end else if (gnt_d_s) begin
            state_d  = DBUS;
            cnt_d    = CNT_ZERO;
            m_cmd_d  = 1'b1;
            m_addr_d = d_addr_s;
            m_rnw_d  = d_rnw_s;
            m_ben_d  = d_ben_s;
            m_data_d = d_data_s;
        end else begin
            m_cmd_d = 1'b0;
        end
    end

    // All state and memory-side outputs; reset aborts any transaction.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            cnt_q    <= CNT_ZERO;
            i_pend_q <= 1'b0;
            i_addr_q <= {ADDR_WIDTH{1'b0}};
            d_pend_q <= 1'b0;
            d_addr_q <= {ADDR_WIDTH{1'b0}};
            d_rnw_q  <= 1'b0;
            d_ben_q  <= {BEN_WIDTH{1'b0}};
            d_data_q <= {DATA_WIDTH{1'b0}};
            m_cmd_q  <= 1'b0;
            m_addr_q <= {ADDR_WIDTH{1'b0}};
            m_rnw_q  <= 1'b0;
            m_ben_q  <= {BEN_WIDTH{1'b0}};
            m_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            i_pend_q <= i_pend_d;
            i_addr_q <= i_addr_d;
            d_pend_q <= d_pend_d;
            d_addr_q <= d_addr_d;
            d_rnw_q  <= d_rnw_d;
            d_ben_q  <= d_ben_d;
            d_data_q <= d_data_d;
            m_cmd_q  <= m_cmd_d;
            m_addr_q <= m_addr_d;
            m_rnw_q  <= m_rnw_d;
            m_ben_q  <= m_ben_d;
            m_data_q <= m_data_d;
        end
    end

    assign o_MCmd  = m_cmd_q;
    assign o_MAddr = m_addr_q;
    assign o_MRnW  = m_rnw_q;
    assign o_MBen  = m_ben_q;
    assign o_MData = m_data_q;

    // Route the memory response back to the port that owns the bus.
    always_comb begin
        o_IRdy = (state_q == IBUS) & rdy_s;
        o_IErr = (state_q == IBUS) & err_s;
        o_DRdy = (state_q == DBUS) & rdy_s;
        o_DErr = (state_q == DBUS) & err_s;
        if (state_q == IBUS) begin
            o_IData = i_MData;
        end else begin
            o_IData = {DATA_WIDTH{1'b0}};
        end
        if (state_q == DBUS) begin
            o_DData = i_MData;
        end else begin
            o_DData = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model (TIMEOUT = 4).

module tb_mem_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] i_IAddr, i_DAddr, i_DData, i_MData;
    logic        i_IRdC, i_DCmd, i_DRnW, i_MRdy, i_MErr;
    logic [3:0]  i_DBen;
    logic [31:0] o_IData, o_DData, o_MAddr, o_MData;
    logic        o_IRdy, o_IErr, o_DRdy, o_DErr, o_MCmd, o_MRnW;
    logic [3:0]  o_MBen;

    mem_arb #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .nrst(nrst),
        .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
        .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen), .i_DData(i_DData),
        .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
        .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MRnW(o_MRnW), .o_MBen(o_MBen), .o_MData(o_MData),
        .i_MData(i_MData), .i_MRdy(i_MRdy), .i_MErr(i_MErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: per-port request slots, current owner (-1 none, 0 I, 1 D),
    // cycle in which the owner's command appears, and last served port.
    bit          pv[2];
    logic [31:0] pa[2];
    bit          prnw[2];
    logic [3:0]  pben[2];
    logic [31:0] pdat[2];
    int          cur;
    int          last;
    int          gcyc;
    logic [31:0] ex_maddr, ex_mdata;
    bit          ex_mrnw;
    logic [3:0]  ex_mben;
    bit          e_err, e_rdy;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pa[p] = 32'h0; prnw[p] = 1'b0; pben[p] = 4'h0; pdat[p] = 32'h0;
        end
        cur = -1; last = 1; gcyc = -100;
        ex_maddr = 32'h0; ex_mdata = 32'h0; ex_mrnw = 1'b0; ex_mben = 4'h0;
    endtask

    task automatic clear_strobes();
        i_IRdC = 1'b0; i_DCmd = 1'b0; i_MRdy = 1'b0; i_MErr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_IRdy"}, o_IRdy, 0);
        check_val({tag, "_IErr"}, o_IErr, 0);
        check_val({tag, "_DRdy"}, o_DRdy, 0);
        check_val({tag, "_DErr"}, o_DErr, 0);
        check_val({tag, "_IData"}, o_IData, 0);
        check_val({tag, "_DData"}, o_DData, 0);
        check_val({tag, "_MCmd"}, o_MCmd, 0);
        check_val({tag, "_MAddr"}, o_MAddr, 0);
        check_val({tag, "_MRnW"}, o_MRnW, 0);
        check_val({tag, "_MBen"}, o_MBen, 0);
        check_val({tag, "_MData"}, o_MData, 0);
    endtask

    // Compare all outputs at the negedge against the model's view of this cycle.
    task automatic check_phase();
        bit busy;
        int age;
        @(negedge clk);
        busy  = (cur >= 0);
        age   = cyc - gcyc;
        e_err = busy && (i_MErr || (age == TO));
        e_rdy = busy && i_MRdy && !e_err;
        check_val("o_IRdy", o_IRdy, (cur == 0) && e_rdy);
        check_val("o_IErr", o_IErr, (cur == 0) && e_err);
        check_val("o_DRdy", o_DRdy, (cur == 1) && e_rdy);
        check_val("o_DErr", o_DErr, (cur == 1) && e_err);
        check_val("o_IData", o_IData, (cur == 0) ? i_MData : 32'h0);
        check_val("o_DData", o_DData, (cur == 1) ? i_MData : 32'h0);
        check_val("o_MCmd", o_MCmd, gcyc == cyc);
        check_val("o_MAddr", o_MAddr, ex_maddr);
        check_val("o_MRnW", o_MRnW, ex_mrnw);
        check_val("o_MBen", o_MBen, ex_mben);
        check_val("o_MData", o_MData, ex_mdata);
    endtask

    // Apply the cycle's rules to the model, then move to just after the next edge.
    task automatic end_phase();
        int w;
        if (i_IRdC && !pv[0]) begin
            pv[0] = 1'b1; pa[0] = i_IAddr; prnw[0] = 1'b1; pben[0] = 4'hF; pdat[0] = 32'h0;
        end
        if (i_DCmd && !pv[1]) begin
            pv[1] = 1'b1; pa[1] = i_DAddr; prnw[1] = i_DRnW; pben[1] = i_DBen; pdat[1] = i_DData;
        end
        if (cur >= 0 && (e_err || e_rdy)) begin
            pv[cur] = 1'b0; last = cur; cur = -1;
        end
        if (cur < 0) begin
            w = -1;
            if (pv[0] && pv[1]) w = 1 - last;
            else if (pv[0]) w = 0;
            else if (pv[1]) w = 1;
            if (w >= 0) begin
                cur = w; gcyc = cyc + 1;
                ex_maddr = pa[w]; ex_mrnw = prnw[w]; ex_mben = pben[w]; ex_mdata = pdat[w];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        clear_strobes();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(negedge clk);
        check_zero("rst");
        clear_strobes();
        nrst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_tie(inout logic [31:0] order[$]);
        bit rsp;
        i_IRdC = 1'b1; i_IAddr = 32'h10;
        i_DCmd = 1'b1; i_DAddr = 32'h20; i_DRnW = 1'b1; i_DBen = 4'hF; i_DData = 32'h0;
        for (int j = 0; j < 7; j++) begin
            check_phase();
            rsp = o_MCmd;
            if (o_MCmd) order.push_back(o_MAddr);
            end_phase();
            if (rsp) begin
                i_MRdy = 1'b1; i_MData = $urandom;
            end
        end
    endtask

    initial begin
        logic [31:0] order[$];
        nrst = 1'b0;
        i_IAddr = 32'h0; i_DAddr = 32'h0; i_DData = 32'h0; i_MData = 32'h0;
        i_DRnW = 1'b0; i_DBen = 4'h0;
        clear_strobes();
        do_reset();

        // Single fetch: command in cycle 1, response in cycle 3
        for (int j = 0; j < 5; j++) begin
            if (j == 0) begin i_IRdC = 1'b1; i_IAddr = 32'h100; end
            if (j == 3) begin i_MRdy = 1'b1; i_MData = 32'hDEADBEEF; end
            check_phase();
            if (j == 1) begin
                check_val("s1_mcmd", o_MCmd, 1);
                check_val("s1_maddr", o_MAddr, 32'h100);
                check_val("s1_mrnw", o_MRnW, 1);
                check_val("s1_mben", o_MBen, 4'hF);
            end
            if (j == 3) begin
                check_val("s1_irdy", o_IRdy, 1);
                check_val("s1_idata", o_IData, 32'hDEADBEEF);
            end
            end_phase();
        end

        // Tie twice from reset: I, D, I, D
        do_reset();
        run_tie(order);
        run_tie(order);
        check_val("tie_count", order.size(), 4);
        check_val("tie_0", order[0], 32'h10);
        check_val("tie_1", order[1], 32'h20);
        check_val("tie_2", order[2], 32'h10);
        check_val("tie_3", order[3], 32'h20);

        // D write in flight, I arrives and a second D strobe is ignored
        for (int j = 0; j < 7; j++) begin
            if (j == 0) begin
                i_DCmd = 1'b1; i_DRnW = 1'b0; i_DAddr = 32'h200; i_DBen = 4'h3; i_DData = 32'h1234;
            end
            if (j == 1) begin
                i_IRdC = 1'b1; i_IAddr = 32'h300;
                i_DCmd = 1'b1; i_DRnW = 1'b1; i_DAddr = 32'h999; i_DBen = 4'hF; i_DData = 32'hFFFF;
            end
            if (j == 3 || j == 5) begin i_MRdy = 1'b1; i_MData = $urandom; end
            check_phase();
            if (j == 1 || j == 2) begin
                check_val("s3_maddr", o_MAddr, 32'h200);
                check_val("s3_mrnw", o_MRnW, 0);
                check_val("s3_mben", o_MBen, 4'h3);
                check_val("s3_mdata", o_MData, 32'h1234);
            end
            if (j == 3) check_val("s3_drdy", o_DRdy, 1);
            if (j == 4) begin
                check_val("s3_i_mcmd", o_MCmd, 1);
                check_val("s3_i_maddr", o_MAddr, 32'h300);
            end
            if (j == 6) check_val("s3_no_dup", o_MCmd, 0);
            end_phase();
        end

        // Timeout: error 4 cycles after the command, late ready ignored
        for (int j = 0; j < 8; j++) begin
            if (j == 0) begin i_DCmd = 1'b1; i_DRnW = 1'b1; i_DAddr = 32'h400; i_DBen = 4'hF; end
            if (j == 6) begin i_MRdy = 1'b1; i_MData = 32'h55; end
            check_phase();
            if (j == 4) check_val("tmo_early", o_DErr, 0);
            if (j == 5) check_val("tmo_err", o_DErr, 1);
            if (j == 6) begin
                check_val("tmo_late_rdy", o_DRdy, 0);
                check_val("tmo_late_err", o_DErr, 0);
            end
            end_phase();
        end

        // Ready and error together: error only
        for (int j = 0; j < 4; j++) begin
            if (j == 0) begin i_IRdC = 1'b1; i_IAddr = 32'h500; end
            if (j == 2) begin i_MRdy = 1'b1; i_MErr = 1'b1; end
            check_phase();
            if (j == 2) begin
                check_val("both_ierr", o_IErr, 1);
                check_val("both_irdy", o_IRdy, 0);
            end
            end_phase();
        end

        // Reset in the middle of a D transaction
        i_DCmd = 1'b1; i_DRnW = 1'b1; i_DAddr = 32'h600; i_DBen = 4'hF;
        check_phase(); end_phase();
        check_phase();
        check_val("rmid_cmd", o_MCmd, 1);
        end_phase();
        i_MRdy = 1'b1;
        nrst = 1'b0;
        #1;
        check_zero("rmid");
        do_reset();
        for (int j = 0; j < 3; j++) begin
            if (j == 0) begin i_IRdC = 1'b1; i_IAddr = 32'h700; i_MRdy = 1'b1; end
            check_phase();
            if (j == 0) check_val("rmid_no_cpl", o_DRdy, 0);
            if (j == 1) check_val("rmid_idle_grant", o_MAddr, 32'h700);
            if (j == 2) begin i_MRdy = 1'b0; end
            end_phase();
        end
        i_MRdy = 1'b1;
        check_phase(); end_phase();

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) do_reset();
            i_IRdC  = ($urandom_range(0, 3) == 0);
            i_IAddr = $urandom;
            i_DCmd  = ($urandom_range(0, 3) == 0);
            i_DAddr = $urandom;
            i_DRnW  = 1'($urandom);
            i_DBen  = 4'($urandom);
            i_DData = $urandom;
            i_MRdy  = ($urandom_range(0, 2) == 0);
            i_MErr  = ($urandom_range(0, 9) == 0);
            i_MData = $urandom;
            check_phase();
            end_phase();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- BEN_WIDTH, 4, byte-enable width
- TIMEOUT, 256, response timeout in cycles; 0 disables the timeout
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- i_IAddr  in  ADDR_WIDTH  fetch address
- i_IRdC  in  1  fetch read strobe
- o_IData  out  DATA_WIDTH  fetch data
- o_IRdy  out  1  fetch done
- o_IErr  out  1  fetch error
- i_DAddr  in  ADDR_WIDTH  data address
- i_DCmd  in  1  data command strobe
- i_DRnW  in  1  1=read, 0=write
- i_DBen  in  BEN_WIDTH  byte enables
- i_DData  in  DATA_WIDTH  write data
- o_DData  out  DATA_WIDTH  read data
- o_DRdy  out  1  data done
- o_DErr  out  1  data error
- o_MAddr  out  ADDR_WIDTH  memory address
- o_MCmd  out  1  memory command strobe
- o_MRnW  out  1  memory read/not-write
- o_MBen  out  BEN_WIDTH  memory byte enables
- o_MData  out  DATA_WIDTH  memory write data
- i_MData  in  DATA_WIDTH  memory read data
- i_MRdy  in  1  memory done
- i_MErr  in  1  memory error

Function
REQ-004 Each requester strobe (i_IRdC, i_DCmd) SHALL be a one-cycle pulse; on a strobe, the block SHALL latch the pending flag and payload into that port's holding register at the same edge.
REQ-005 A strobe on a port whose request is already pending or in flight SHALL be ignored.
REQ-006 The FSM SHALL have states IDLE, IBUS and DBUS.
REQ-007 In IDLE with at least one request (pending flag, or strobe in the current cycle), the FSM SHALL grant at the next edge, so the earliest o_MCmd is in cycle N+1 after a strobe in cycle N.
REQ-008 When both ports request in the same IDLE cycle, the grant SHALL go to the port not served last (round-robin); the last-served flag SHALL reset to D, so I wins the first tie.
REQ-009 On grant, the block SHALL register o_MAddr, o_MRnW, o_MBen and o_MData from the winning port and assert o_MCmd for exactly one cycle.
- I grant: o_MRnW=1, o_MBen all ones, o_MData=0.
- Outputs other than o_MCmd SHALL hold until the transaction completes.
REQ-010 In IBUS/DBUS, i_MRdy SHALL route combinationally to o_IRdy or o_DRdy of the granted port, with o_IData/o_DData = i_MData.
REQ-011 In IBUS/DBUS, i_MErr SHALL route combinationally to o_IErr or o_DErr of the granted port.
REQ-012 On completion, the FSM SHALL return to IDLE at that edge, clear the pending flag and update last-served.
- Earliest next o_MCmd: cycle M+1 after completion in cycle M.
REQ-013 If i_MRdy and i_MErr are both high, Err SHALL win and Rdy SHALL be suppressed.
REQ-014 i_MRdy/i_MErr received in IDLE SHALL be ignored.
REQ-015 With TIMEOUT>0, a cycle counter SHALL start at o_MCmd.
- If TIMEOUT cycles elapse with no response, the block SHALL pulse the granted port's Err for one cycle and return to IDLE.
- A late response after a timeout SHALL be ignored.
REQ-016 o_IRdy, o_IErr, o_DRdy and o_DErr SHALL be mutually exclusive and low outside IBUS/DBUS.
REQ-017 A new strobe on the other port during a transaction SHALL be latched and served next.

Reset
REQ-018 While nrst=0, the block SHALL be in IDLE with pending flags cleared, last-served=D, timeout counter=0, and all outputs 0.
REQ-019 Reset asserted mid-transaction SHALL abort the transaction with no Rdy/Err to any requester.

Verification
REQ-020 The bench SHALL cover these scenarios:
- i_IRdC at cycle 0 with i_IAddr=0x100, i_MRdy at cycle 3 with i_MData=0xDEADBEEF -> o_MCmd in cycle 1 (o_MAddr=0x100, o_MRnW=1, o_MBen=0xF); o_IRdy=1 and o_IData=0xDEADBEEF in cycle 3.
- i_IRdC and i_DCmd in the same cycle, then both repeated -> order I, D, I, D.
- D write (0x200, Ben=0x3, data=0x1234) in flight while i_IRdC arrives -> I o_MCmd in cycle after o_DRdy; D payload unchanged during its transaction.
- TIMEOUT=4 with no response -> o_DErr pulse 4 cycles after o_MCmd; late i_MRdy ignored.
- i_MRdy and i_MErr high together -> Err only.
- nrst low mid-transaction -> all outputs 0, FSM in IDLE, no completion pulse.
